// File: rtl/fetch_pkg.sv
// Shared types and default encodings for the fetch stage.
// No logic; the helper keeps PC arithmetic modulo 2^32 in one place.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] DEFAULT_NOP_WORD  = 32'h0000_0013;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: holds the fetched word, its PC and link value.
// Latency 1 cycle from load; flush beats load, neither means hold (stall).
module if_id_register
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] instruction,
    input  logic [31:0] pc,
    output logic        valid,
    output logic [31:0] instruction_q,
    output logic [31:0] pc_q,
    output logic [31:0] pc_plus4_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid         <= 1'b0;
            instruction_q <= NOP_WORD;
            pc_q          <= 32'h0;
            pc_plus4_q    <= 32'h0;
        end else if (flush) begin
            // PC fields are left alone: only the word and valid describe a bubble
            valid         <= 1'b0;
            instruction_q <= NOP_WORD;
        end else if (load) begin
            valid         <= 1'b1;
            instruction_q <= instruction;
            pc_q          <= pc;
            pc_plus4_q    <= pc_plus4(pc);
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, captures the memory word into IF/ID, handles redirect and halt.
// Latency: word at pc appears on idInstruction 1 cycle later; idValid && !idReady stalls pc and IF/ID.
// FETCH_MISALIGN_TRAP_EN adds a FAULT state and fetchFault on misaligned redirect targets.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD,
    parameter logic [31:0] NOP_WORD  = DEFAULT_NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] instructionAddress,
    input  logic [31:0] instruction,
    input  logic        redirectValid,
    input  logic [31:0] redirectTarget,
    input  logic        idReady,
    output logic        idValid,
    output logic [31:0] idInstruction,
    output logic [31:0] idPc,
    output logic [31:0] idPcPlus4,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        fetchFault,
`endif
    output logic        halted
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         stall;
    logic         is_halt_word;
    logic         take_redirect;
    logic         if_load;
    logic         if_flush;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic         misaligned;
    assign misaligned = |redirectTarget[1:0];
`else
    logic [31:0]  aligned_target;
    assign aligned_target = redirectTarget & ~32'd3;
`endif

    assign instructionAddress = pc;
    assign stall         = idValid && !idReady;
    assign is_halt_word  = (instruction == HALT_WORD);
    assign take_redirect = redirectValid && (state != FAULT);

    // Redirect flushes even while stalled; halt word is squashed into a bubble.
    assign if_flush = take_redirect || ((state == RUN) && !stall && is_halt_word);
    assign if_load  = (state == RUN) && !redirectValid && !stall && !is_halt_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            state  <= RUN;
            halted <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fetchFault <= 1'b0;
`endif
        end else if (take_redirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            pc <= redirectTarget;
            if (misaligned) begin
                state      <= FAULT;
                halted     <= 1'b1;
                fetchFault <= 1'b1;
            end else begin
                state  <= RUN;
                halted <= 1'b0;
            end
`else
            pc     <= aligned_target;
            state  <= RUN;
            halted <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    if (!stall) begin
                        if (is_halt_word) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            pc <= pc_plus4(pc);
                        end
                    end
                end
                HALT:    ;
                FAULT:   ;
                default: state <= RUN;
            endcase
        end
    end

    if_id_register #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (if_load),
        .flush         (if_flush),
        .instruction   (instruction),
        .pc            (pc),
        .valid         (idValid),
        .instruction_q (idInstruction),
        .pc_q          (idPc),
        .pc_plus4_q    (idPcPlus4)
    );

endmodule
